mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits in the EX stage beside the ALU and takes the same forwarded RS/RT operands and EX-stage instruction word. It produces a Busy flag for the hazard unit and an mfhi/mflo read value. The EX/MEM pipeline register captures that read value in place of ALUout.

## Interface
- MULT_CYCLES, 5: Busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10: Busy cycles for div/divu (≥1).
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- RSE  in  32  forwarded rs operand in EX.
- RTE  in  32  forwarded rt operand in EX.
- IRE  in  32  EX-stage instruction word; decoded internally (op 31:26, func 5:0).
- Start  out  1  combinational; IRE is mult/multu/div/divu and the unit accepts it.
- Busy  out  1  registered; an operation is in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.
- MDout  out  32  combinational; HI for mfhi, LO for mflo, else 0.

## Operation
- Decoded R-type funcs: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011. All other IRE values have no effect.
- Pipeline contract: each instruction occupies EX for exactly one cycle. The hazard unit freezes F/D and bubbles E while an md-class instruction (mult/div/mf/mt) is in D and Start||Busy is true.
- States: IDLE, MUL, DIV, held in a state register plus a down-counter.
- IDLE + Start: latch RSE, RTE, signedness and kind. Load counter with MULT_CYCLES or DIV_CYCLES. Go to MUL or DIV; Busy=1 next cycle.
- MUL/DIV: decrement counter each cycle. On the cycle the counter is 1, write the result at that edge and return to IDLE.
- mult: {HI,LO} = signed 64-bit product. multu: unsigned product.
- div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- divu: unsigned quotient and remainder.
- Divide by zero: HI/LO unchanged; Busy still runs the full DIV_CYCLES.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo in IDLE: write RSE to HI/LO at the end of that cycle.
- Start, mthi and mtlo are ignored while Busy (Start is forced 0). A contract violation therefore cannot corrupt an in-flight result.
- MDout reads the current registers. An mf issued the cycle after a mt sees the new value.

## Timing
- Reset values: HI=0, LO=0, Busy=0, state IDLE, counter 0, Start=0 under reset.
- Reset mid-operation: the in-flight result is discarded; the unit is in IDLE next cycle.
- Start in cycle t:
  - Busy is high in cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO take the result at the edge ending cycle t+N.
  - Busy is low in t+N+1.
- An md instruction may enter EX in cycle t+N+1 and sees the new HI/LO.
- mthi/mtlo latency: 1 edge.
- MDout latency: 0, combinational from IRE and the registers.

## Configuration
- MDU_DIV_EN defined: div/divu are implemented as above.
- MDU_DIV_EN undefined:
  - div/divu are not decoded; Start=0 for them and they behave as nop.
  - No divider logic or DIV state is built.
  - DIV_CYCLES is unused.

## Test plan
- multu RSE=0xFFFFFFFF, RTE=2 -> Busy high for exactly 5 cycles; then HI=0x00000001, LO=0xFFFFFFFE.
- mult RSE=0xFFFFFFFD (−3), RTE=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; mflo next cycle gives MDout=0xFFFFFFF1.
- div RSE=0xFFFFFFF9 (−7), RTE=2 -> after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu by zero with HI=0x11, LO=0x22 -> Busy for 10 cycles; HI/LO remain 0x11/0x22.
- mult started, reset asserted in the 3rd Busy cycle -> next cycle Busy=0, HI=LO=0, no late write.
- mthi RSE=0xDEADBEEF, then mthi issued while Busy -> first writes HI; the second is ignored and HI ends with the operation result.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Ports: clk, reset (sync, active-high); RSE/RTE forwarded operands and IRE EX-stage
// instruction; Start (comb, md op accepted), Busy (op in flight), HI/LO registers,
// MDout (comb mfhi/mflo read value, else 0).
// Build option: define MDU_DIV_EN to build div/divu; otherwise they decode as nop.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] RSE,
    input  logic [31:0] RTE,
    input  logic [31:0] IRE,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);
`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
`else
    typedef enum logic {IDLE, MUL} state_t;
    localparam int MAXC = MULT_CYCLES;
    localparam int unused_div_cycles = DIV_CYCLES;
`endif
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] ONE = 1;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic sgn_q, sgn_d;
    logic rtype, is_mul, is_mfhi, is_mflo, is_mthi, is_mtlo, idle;
    logic [63:0] ea, eb, prod;
    logic unused_ire;

    assign rtype   = IRE[31:26] == 6'b000000;
    assign is_mul  = rtype && IRE[5:1] == 5'b01100;
    assign is_mfhi = rtype && IRE[5:0] == 6'b010000;
    assign is_mthi = rtype && IRE[5:0] == 6'b010001;
    assign is_mflo = rtype && IRE[5:0] == 6'b010010;
    assign is_mtlo = rtype && IRE[5:0] == 6'b010011;
    assign unused_ire = ^IRE[25:6];
    assign idle  = state_q == IDLE;
    assign Busy  = !idle;
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDout = is_mfhi ? hi_q : is_mflo ? lo_q : 32'b0;

    // Sign-extending only for the signed variant lets one 64-bit multiply serve both.
    assign ea   = {{32{sgn_q & a_q[31]}}, a_q};
    assign eb   = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod = ea * eb;

`ifdef MDU_DIV_EN
    logic is_div;
    logic [31:0] ma, mb, uq, ur, quo, rem;
    assign is_div = rtype && IRE[5:1] == 5'b01101;
    assign Start  = !reset && idle && (is_mul || is_div);
    // Divide magnitudes, then restore signs: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
    assign ma  = (sgn_q && a_q[31]) ? -a_q : a_q;
    assign mb  = (sgn_q && b_q[31]) ? -b_q : b_q;
    assign uq  = (mb == 32'b0) ? 32'b0 : ma / mb;
    assign ur  = (mb == 32'b0) ? 32'b0 : ma % mb;
    assign quo = (sgn_q && (a_q[31] ^ b_q[31])) ? -uq : uq;
    assign rem = (sgn_q && a_q[31]) ? -ur : ur;
`else
    assign Start = !reset && idle && is_mul;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (idle) begin
            if (Start) begin
                a_d     = RSE;
                b_d     = RTE;
                sgn_d   = !IRE[0];
                state_d = MUL;
                cnt_d   = CW'(MULT_CYCLES);
`ifdef MDU_DIV_EN
                if (is_div) begin
                    state_d = DIV;
                    cnt_d   = CW'(DIV_CYCLES);
                end
`endif
            end
            if (is_mthi) hi_d = RSE;
            if (is_mtlo) lo_d = RSE;
        end else begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
                state_d = IDLE;
                if (state_q == MUL) {hi_d, lo_d} = prod;
`ifdef MDU_DIV_EN
                else if (b_q != 32'b0) begin
                    hi_d = rem;
                    lo_d = quo;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, hand sequences and random ops against an arithmetic model.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    logic [31:0] RSE, RTE, IRE;
    logic Start, Busy;
    logic [31:0] HI, LO, MDout;
    int total = 0;
    int bad = 0;
    logic [31:0] mhi = 0, mlo = 0;

`ifdef MDU_DIV_EN
    localparam bit DIVON = 1'b1;
`else
    localparam bit DIVON = 1'b0;
`endif
    localparam int DC = DIVON ? 10 : 0;

    typedef struct {
        logic [31:0] ir, rs, rt, md, hi, lo;
        int cyc;
    } vec_t;
    vec_t v[16];
    logic [5:0] fl[10] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00, 6'h2A};

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .RSE(RSE), .RTE(RTE), .IRE(IRE),
        .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDout(MDout)
    );

    function automatic logic [31:0] enc(input logic [5:0] f);
        return {26'b0, f};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic int ncyc(input logic [31:0] ir);
        if (ir[31:26] != 6'b0) return 0;
        if (ir[5:1] == 5'b01100) return 5;
        if (ir[5:1] == 5'b01101) return DC;
        return 0;
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural registers.
    task automatic model(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rt);
        longint a, b;
        logic [63:0] p;
        if (ir[31:26] != 6'b0) return;
        case (ir[5:0])
            6'h11: mhi = rs;
            6'h13: mlo = rs;
            6'h18: begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                p = 64'(a * b);
                {mhi, mlo} = p;
            end
            6'h19: begin
                p = {32'b0, rs} * {32'b0, rt};
                {mhi, mlo} = p;
            end
            6'h1A, 6'h1B: if (DIVON && rt != 0) begin
                a = ir[0] ? longint'({32'b0, rs}) : longint'($signed(rs));
                b = ir[0] ? longint'({32'b0, rt}) : longint'($signed(rt));
                mlo = 32'(a / b);
                mhi = 32'(a % b);
            end
            default: ;
        endcase
    endtask

    task automatic run(input logic [31:0] ir, rs, rt, md, hi, lo, input int cyc, input string nm);
        int n = 0;
        IRE = ir;
        RSE = rs;
        RTE = rt;
        #1;
        chk({nm, ".start"}, 64'(Start), 64'(cyc > 0));
        chk({nm, ".mdout"}, 64'(MDout), 64'(md));
        @(posedge clk);
        #1;
        IRE = 32'b0;
        RSE = $urandom;
        RTE = $urandom;
        while (Busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk({nm, ".busy"}, 64'(n), 64'(cyc));
        chk({nm, ".hi"}, 64'(HI), 64'(hi));
        chk({nm, ".lo"}, 64'(LO), 64'(lo));
    endtask

    initial begin
        int n;
        logic [31:0] ir, rs, rt, md;
        v[0]  = '{enc(6'h19), 32'hFFFFFFFF, 32'h2, 32'h0, 32'h1, 32'hFFFFFFFE, 5};
        v[1]  = '{enc(6'h18), 32'hFFFFFFFD, 32'h5, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        v[2]  = '{enc(6'h12), 32'h0, 32'h0, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0};
        v[3]  = '{enc(6'h10), 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF1, 0};
        v[4]  = '{enc(6'h1A), 32'hFFFFFFF9, 32'h2, 32'h0, 32'hFFFFFFFF,
                  DIVON ? 32'hFFFFFFFD : 32'hFFFFFFF1, DC};
        v[5]  = '{enc(6'h11), 32'h11, 32'h0, 32'h0, 32'h11,
                  DIVON ? 32'hFFFFFFFD : 32'hFFFFFFF1, 0};
        v[6]  = '{enc(6'h13), 32'h22, 32'h0, 32'h0, 32'h11, 32'h22, 0};
        v[7]  = '{enc(6'h1B), 32'h5, 32'h0, 32'h0, 32'h11, 32'h22, DC};
        v[8]  = '{enc(6'h1A), 32'h80000000, 32'hFFFFFFFF, 32'h0,
                  DIVON ? 32'h0 : 32'h11, DIVON ? 32'h80000000 : 32'h22, DC};
        v[9]  = '{enc(6'h1B), 32'hFFFFFFFF, 32'h10, 32'h0,
                  DIVON ? 32'hF : 32'h0, DIVON ? 32'h0FFFFFFF : 32'h80000000, DC};
        if (!DIVON) v[9].hi = 32'h11;
        if (!DIVON) v[9].lo = 32'h22;
        v[10] = '{{6'h23, 20'h0, 6'h18}, 32'h5, 32'h5, 32'h0, v[9].hi, v[9].lo, 0};
        v[11] = '{enc(6'h18), 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h3FFFFFFF, 32'h00000001, 5};
        v[12] = '{enc(6'h18), 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 32'h0, 5};
        v[13] = '{enc(6'h13), 32'hDEAD, 32'h0, 32'h0, 32'h40000000, 32'hDEAD, 0};
        v[14] = '{enc(6'h12), 32'h0, 32'h0, 32'hDEAD, 32'h40000000, 32'hDEAD, 0};
        v[15] = '{enc(6'h3F), 32'h1, 32'h1, 32'h0, 32'h40000000, 32'hDEAD, 0};

        reset = 1'b1;
        IRE = 32'b0;
        RSE = 32'b0;
        RTE = 32'b0;
        repeat (2) @(posedge clk);
        #1;
        IRE = enc(6'h18);
        #1;
        chk("rst.start", 64'(Start), 64'(0));
        chk("rst.busy", 64'(Busy), 64'(0));
        chk("rst.hi", 64'(HI), 64'(0));
        chk("rst.lo", 64'(LO), 64'(0));
        reset = 1'b0;
        IRE = 32'b0;

        foreach (v[i]) run(v[i].ir, v[i].rs, v[i].rt, v[i].md, v[i].hi, v[i].lo, v[i].cyc,
                           $sformatf("vec%0d", i));

        // Reset in the third Busy cycle discards the in-flight product.
        IRE = enc(6'h18);
        RSE = 32'h3;
        RTE = 32'h4;
        @(posedge clk);
        #1;
        IRE = 32'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rmid.busy3", 64'(Busy), 64'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rmid.busy", 64'(Busy), 64'(0));
        chk("rmid.hi", 64'(HI), 64'(0));
        chk("rmid.lo", 64'(LO), 64'(0));
        repeat (6) @(posedge clk);
        #1;
        chk("rmid.late_hi", 64'(HI), 64'(0));
        chk("rmid.late_lo", 64'(LO), 64'(0));

        // mthi lands, then a second mthi and a mult issued while Busy are both ignored.
        IRE = enc(6'h11);
        RSE = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        chk("mt.hi", 64'(HI), 64'(32'hDEADBEEF));
        IRE = enc(6'h18);
        RSE = 32'h6;
        RTE = 32'h7;
        @(posedge clk);
        #1;
        IRE = enc(6'h11);
        RSE = 32'h1234;
        #1;
        chk("mt.busy_start0", 64'(Start), 64'(0));
        @(posedge clk);
        #1;
        chk("mt.hi_hold", 64'(HI), 64'(32'hDEADBEEF));
        IRE = enc(6'h18);
        RSE = 32'h9;
        RTE = 32'h9;
        #1;
        chk("mt.busy_start1", 64'(Start), 64'(0));
        @(posedge clk);
        #1;
        IRE = 32'b0;
        n = 0;
        while (Busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("mt.remain", 64'(n), 64'(3));
        chk("mt.res_hi", 64'(HI), 64'(0));
        chk("mt.res_lo", 64'(LO), 64'(42));
        mhi = 32'h0;
        mlo = 32'd42;

        for (int k = 0; k < 40; k++) begin
            ir = {6'b0, 20'($urandom), fl[$urandom_range(0, 9)]};
            if ($urandom_range(0, 7) == 0) ir[31:26] = 6'($urandom_range(1, 63));
            rs = $urandom;
            rt = ($urandom_range(0, 7) == 0) ? 32'b0 : $urandom;
            if ($urandom_range(0, 3) == 0) rt = 32'($urandom_range(0, 20)) - 32'd10;
            md = (ir[31:26] == 6'b0 && ir[5:0] == 6'h10) ? mhi :
                 (ir[31:26] == 6'b0 && ir[5:0] == 6'h12) ? mlo : 32'b0;
            model(ir, rs, rt);
            run(ir, rs, rt, md, mhi, mlo, ncyc(ir), $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
